// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM encoding, width default.
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // 4-bit operation codes from ALU control
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1010;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low W bits kept.
// done is combinational and marks the cycle whose edge performs the final step,
// with product already holding that final sum, so the caller can register it
// on the same edge.
module alu_multiplier #(
  parameter int W     = 32,
  parameter int STEPS = W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(STEPS) + 1;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(STEPS - 1));
  assign product = acc_q + (b_q[0] ? a_q : '0);

  // Load operands on start, then add the shifted multiplicand per set multiplier bit
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      acc_d = product;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  // State registers; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative MUL.
// Results and flags are registered and held until the next valid_o pulse.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MUL_STEPS  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic [4:0]            shamt_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  overflow_o,
  output logic                  invalid_o
);

  localparam int MSB = DATA_WIDTH - 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  inv_q, inv_d;

  logic [DATA_WIDTH-1:0] sum, diff, alu_res;
  logic                  alu_ovf, alu_inv;
  logic                  mul_start, mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  alu_multiplier #(
    .W     (DATA_WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_data_i),
    .b       (b_data_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Multiplier busy is folded in so ready can never overlap a running multiply
  assign ready_o    = (state_q == ST_IDLE) && !mul_busy;
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign invalid_o  = inv_q;

  // Single-cycle datapath; LUI places b[15:0] in the upper half
  always_comb begin
    sum     = a_data_i + b_data_i;
    diff    = a_data_i - b_data_i;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_inv = 1'b0;
    case (alu_operation_i)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_data_i[MSB] == b_data_i[MSB]) && (sum[MSB] != a_data_i[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_data_i[MSB] != b_data_i[MSB]) && (diff[MSB] != a_data_i[MSB]);
      end
      OP_OR:  alu_res = a_data_i | b_data_i;
      OP_AND: alu_res = a_data_i & b_data_i;
      OP_NOR: alu_res = ~(a_data_i | b_data_i);
      OP_LUI: alu_res = b_data_i << 16;
      OP_SLL: alu_res = b_data_i << shamt_i;
      OP_SRL: alu_res = b_data_i >> shamt_i;
      OP_MUL: alu_res = '0;
      default: alu_inv = 1'b1;
    endcase
  end

  // FSM next state and output register updates
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && ready_o) begin
          if (alu_operation_i == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_BUSY;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            inv_d    = alu_inv;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          ovf_d    = 1'b0;
          inv_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state and outputs; reset wins over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, corner sequences, random vs model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_data_i, b_data_i;
  logic [4:0]  shamt_i;
  logic        ready_o, valid_o, zero_o, overflow_o, invalid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  alu_multicycle dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_data_i        (a_data_i),
    .b_data_i        (b_data_i),
    .shamt_i         (shamt_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .overflow_o      (overflow_o),
    .invalid_o       (invalid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf, inv;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on wide integers
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic o,
                                output logic inv);
    longint s;
    logic [63:0] p;
    r = 0; o = 0; inv = 0;
    case (op)
      OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_OR:  r = a | b;
      OP_AND: r = a & b;
      OP_NOR: r = ~(a | b);
      OP_LUI: r = {b[15:0], 16'h0000};
      OP_SLL: r = b << sh;
      OP_SRL: r = b >> sh;
      OP_MUL: begin p = 64'(a) * 64'(b); r = p[31:0]; end
      default: inv = 1;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, wait (bounded) for valid_o.
  // lat = edges after the accepting edge; rdy_low = busy cycles seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit poke_busy, output int lat,
                        output int rdy_low);
    start_i = 1; alu_operation_i = op; a_data_i = a; b_data_i = b; shamt_i = sh;
    @(posedge clk); #1;
    start_i = 0; alu_operation_i = 4'($urandom);
    a_data_i = $urandom; b_data_i = $urandom; shamt_i = 5'($urandom);
    lat = 0; rdy_low = 0;
    while (!valid_o && lat < 200) begin
      if (!ready_o) rdy_low++;
      start_i = (poke_busy && lat == 5);
      alu_operation_i = OP_ADD;
      @(posedge clk); #1;
      lat++;
    end
    start_i = 0;
    chk("valid_seen", 32'(valid_o), 32'd1);
  endtask

  vec_t tbl[13];
  logic [31:0] er;
  logic        eo, ei;
  logic [31:0] rsave;
  int          lat, rlow, seen;
  logic [3:0]  ops[16];
  logic [31:0] pick[5];

  initial begin
    tbl[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b0, 0};
    tbl[1]  = '{OP_SUB, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 0};
    tbl[2]  = '{OP_ADD, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h00000000, 1'b0, 1'b0, 0};
    tbl[3]  = '{OP_SUB, 32'h5,        32'h5,        5'd0,  32'h00000000, 1'b0, 1'b0, 0};
    tbl[4]  = '{OP_OR,  32'hF0,       32'h0F,       5'd0,  32'h000000FF, 1'b0, 1'b0, 0};
    tbl[5]  = '{OP_NOR, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0};
    tbl[6]  = '{OP_LUI, 32'hDEADBEEF, 32'h00001234, 5'd3,  32'h12340000, 1'b0, 1'b0, 0};
    tbl[7]  = '{OP_SRL, 32'h0,        32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 0};
    tbl[8]  = '{OP_SLL, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0, 0};
    tbl[9]  = '{4'b1001, 32'h5,       32'h7,        5'd0,  32'h00000000, 1'b0, 1'b1, 0};
    tbl[10] = '{OP_AND, 32'hF0,       32'h3C,       5'd0,  32'h00000030, 1'b0, 1'b0, 0};
    tbl[11] = '{OP_MUL, 32'h0000FFFF, 32'h00010001, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 32};
    tbl[12] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b0, 1'b1, 0};

    // Reset state
    reset = 1; start_i = 0; alu_operation_i = 0; a_data_i = 0; b_data_i = 0; shamt_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_o, 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_zero", 32'(zero_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_inv", 32'(invalid_o), 0);
    reset = 0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready_o), 1);

    // Directed table, one idle cycle after each op to check pulse width and hold
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].op == OP_MUL, lat, rlow);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_rdylow", i), rlow, tbl[i].lat);
      chk($sformatf("tbl%0d_res", i), result_o, tbl[i].res);
      chk($sformatf("tbl%0d_zero", i), 32'(zero_o), 32'(tbl[i].res == 0));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_inv", i), 32'(invalid_o), 32'(tbl[i].inv));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pulse", i), 32'(valid_o), 0);
      chk($sformatf("tbl%0d_hold", i), result_o, tbl[i].res);
    end

    // Back-to-back SUB then LUI: valid high on consecutive cycles
    start_i = 1; alu_operation_i = OP_SUB; a_data_i = 5; b_data_i = 5; shamt_i = 0;
    @(posedge clk); #1;
    chk("b2b_v0", 32'(valid_o), 1);
    chk("b2b_r0", result_o, 0);
    chk("b2b_z0", 32'(zero_o), 1);
    alu_operation_i = OP_LUI; b_data_i = 32'h00001234;
    @(posedge clk); #1;
    chk("b2b_v1", 32'(valid_o), 1);
    chk("b2b_r1", result_o, 32'h12340000);
    chk("b2b_z1", 32'(zero_o), 0);
    start_i = 0;
    @(posedge clk); #1;
    chk("b2b_end", 32'(valid_o), 0);

    // Start in the MUL completion cycle is accepted immediately
    run_op(OP_MUL, 32'd3, 32'd7, 5'd0, 1'b0, lat, rlow);
    chk("mc_mul_res", result_o, 32'd21);
    run_op(OP_ADD, 32'd2, 32'd2, 5'd0, 1'b0, lat, rlow);
    chk("mc_add_lat", lat, 0);
    chk("mc_add_res", result_o, 32'd4);

    // Random ops vs reference model, issued back-to-back
    ops = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOR, OP_LUI, OP_SLL, OP_SRL,
            OP_MUL, OP_ADD, OP_SUB, 4'b0000, 4'b1001, 4'b1011, 4'b1100, 4'b1111};
    pick = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  sh;
      op = ops[$urandom_range(0, 15)];
      a  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      sh = 5'($urandom);
      model(op, a, b, sh, er, eo, ei);
      run_op(op, a, b, sh, 1'b0, lat, rlow);
      chk($sformatf("rnd%0d_op%h_lat", i, op), lat, (op == OP_MUL) ? 32 : 0);
      chk($sformatf("rnd%0d_op%h_res", i, op), result_o, er);
      chk($sformatf("rnd%0d_op%h_zero", i, op), 32'(zero_o), 32'(er == 0));
      chk($sformatf("rnd%0d_op%h_ovf", i, op), 32'(overflow_o), 32'(eo));
      chk($sformatf("rnd%0d_op%h_inv", i, op), 32'(invalid_o), 32'(ei));
    end

    // Reset 10 cycles into a MUL aborts it with no valid pulse
    run_op(OP_OR, 32'h1, 32'h1, 5'd0, 1'b0, lat, rlow);
    start_i = 1; alu_operation_i = OP_MUL; a_data_i = 32'h1234; b_data_i = 32'h5678;
    @(posedge clk); #1;
    start_i = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", 32'(ready_o), 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_result", result_o, 0);
    chk("abort_valid", 32'(valid_o), 0);
    chk("abort_zero", 32'(zero_o), 0);
    chk("abort_ovf", 32'(overflow_o), 0);
    chk("abort_inv", 32'(invalid_o), 0);
    chk("abort_ready", 32'(ready_o), 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("abort_no_valid", seen, 0);

    // Reset wins over start on the same edge
    run_op(OP_OR, 32'h3, 32'h0, 5'd0, 1'b0, lat, rlow);
    rsave = result_o;
    chk("prio_pre", rsave, 32'h3);
    start_i = 1; alu_operation_i = OP_ADD; a_data_i = 1; b_data_i = 1; reset = 1;
    @(posedge clk); #1;
    start_i = 0; reset = 0;
    chk("prio_valid", 32'(valid_o), 0);
    chk("prio_result", result_o, 0);
    @(posedge clk); #1;
    chk("prio_valid2", 32'(valid_o), 0);
    chk("prio_ready", 32'(ready_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: ALU_Multicycle

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the operand and result width.
REQ-002 The block SHALL have parameter MUL_STEPS, default DATA_WIDTH, which sets the number of iterative multiply steps.
REQ-003 The block SHALL have the following ports (clock and reset first):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- start_i  in  1  request to start an operation
- alu_operation_i  in  4  operation code from ALU control
- a_data_i  in  DATA_WIDTH  operand A (rs)
- b_data_i  in  DATA_WIDTH  operand B (rt/immediate)
- shamt_i  in  5  shift amount
- ready_o  out  1  block can accept start_i
- valid_o  out  1  one-cycle pulse when result_o/flags are new
- result_o  out  DATA_WIDTH  registered result
- zero_o  out  1  result_o == 0
- overflow_o  out  1  signed overflow on ADD/SUB
- invalid_o  out  1  unsupported operation code
REQ-004 The one clock is clk; reset is synchronous and active-high; no other clock or asynchronous reset SHALL exist.

Function
REQ-005 An operation SHALL be accepted on a rising edge where start_i=1 and ready_o=1; start_i with ready_o=0 SHALL be ignored (not queued).
REQ-006 Operands and op code SHALL be sampled only at acceptance; later input changes SHALL not affect the operation.
REQ-007 Codes: 0011 ADD, 0100 SUB, 0010 OR, 0110 AND, 0111 NOR, 0101 LUI, 1000 SLL, 1010 SRL, 0001 MUL; every other code (incl. 1001) is INVALID.
REQ-008 ADD/SUB SHALL be mod 2^DATA_WIDTH; overflow_o=1 iff signed overflow; overflow_o=0 for all other ops.
REQ-009 LUI result SHALL be {b[15:0], 16'b0}; SLL = b << shamt_i; SRL = b >> shamt_i (logical, zero fill); NOR = ~(a|b).
REQ-010 MUL result SHALL be the low DATA_WIDTH bits of unsigned a*b, computed by shift-add, one step per cycle.
REQ-011 FSM states: IDLE, MUL_BUSY. IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE after the MUL_STEPS-th step; all other accepted ops stay in IDLE.
REQ-012 ready_o SHALL be 1 in IDLE and 0 in MUL_BUSY.
REQ-013 Non-MUL ops SHALL have latency 1: accepted at edge N gives valid_o=1 with the result in the cycle after edge N.
REQ-014 MUL SHALL have latency MUL_STEPS: accepted at edge N gives valid_o=1 in the cycle after edge N+MUL_STEPS, with ready_o=1 in that same cycle.
REQ-015 Back-to-back non-MUL ops SHALL be accepted every cycle, with valid_o high continuously.
REQ-016 A start_i in the MUL completion cycle SHALL be accepted, since ready_o=1.
REQ-017 valid_o SHALL be a one-cycle pulse per operation.
REQ-018 result_o, zero_o, overflow_o and invalid_o SHALL hold their last values until the next valid_o.
REQ-019 zero_o SHALL be registered together with result_o.
REQ-020 An INVALID code SHALL give result_o=0, zero_o=1, invalid_o=1 with latency 1; invalid_o=0 for valid codes.
REQ-021 The step counter SHALL be log2(MUL_STEPS)+1 bits and SHALL not wrap inside one operation.

Reset
REQ-022 While reset=1 at a rising edge: state=IDLE, counter=0, result_o=0, valid_o=0, zero_o=0, overflow_o=0, invalid_o=0.
REQ-023 ready_o SHALL be 1 in the cycle after reset is released.
REQ-024 Reset during MUL_BUSY SHALL abort the multiply, with no valid_o pulse for the aborted op.
REQ-025 reset SHALL take priority over start_i on the same edge.

Structure
REQ-026 A shared package alu_pkg SHALL hold the 4-bit op code constants, the FSM state encoding and the DATA_WIDTH default.
REQ-027 The iterative multiplier SHALL be one sub-module, ALU_Multiplier, with ports start, busy, done and product; the top holds the FSM, the single-cycle datapath and the output registers.

Verification
REQ-028 ADD a=0x7FFFFFFF, b=1 -> next cycle valid_o=1, result_o=0x80000000, overflow_o=1, zero_o=0.
REQ-029 SUB a=5, b=5, followed back-to-back by LUI b=0x00001234 -> consecutive valid_o pulses: result 0 with zero_o=1, then 0x12340000.
REQ-030 MUL a=0x0000FFFF, b=0x00010001 -> ready_o=0 for 32 cycles; valid_o 32 cycles after accept with result_o=0xFFFFFFFF; a start_i during busy is ignored.
REQ-031 SRL b=0x80000000, shamt=31 -> result_o=1; SLL b=1, shamt=31 -> result_o=0x80000000.
REQ-032 Op code 1001 -> result_o=0, invalid_o=1, zero_o=1; a following AND a=0xF0, b=0x3C -> result_o=0x30, invalid_o=0.
REQ-033 reset asserted 10 cycles into a MUL -> no valid_o pulse; all outputs 0 and ready_o=1 after reset is released.
